tx_ant_switch: RTL and testbench

TX_ANT_SWITCH -- requirements
Module: tx_ant_switch

---
 rtl/tx_ant_switch.sv | 224 ++++++++++++++++++++++
 tb/tb_tx_ant_switch.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_ant_switch.sv
// -----------------------------------------------------------------------------
// tx_ant_switch
//
// Transmit antenna selection and T/R switch sequencing for a two-antenna
// front end. The receive path picks an antenna (rx_ant_select / rx_ant_latch).
// The block remembers that choice and uses it for the next transmit burst:
//   IDLE   -> tx_req accepted, the T/R switch is moved to the TX path
//   SETTLE -> wait for the switch to settle, then pulse tx_ack and enable
//             the PA of the chosen antenna
//   ACTIVE -> forward strobed IQ samples to the chosen antenna (1 cycle latency)
//   TAIL   -> keep the PA on for a short tail after the last sample
//
// Optional feature (macro TX_ANT_FORCE_EN): adds force_ant_en / force_ant,
// which override the antenna choice at tx_req acceptance.
//
// Parameters:
//   IQ_DATA_WIDTH  width of one I or Q component (a sample is 2x this)
//   CNT_WIDTH      width of the settle/tail counter and of the cycle inputs
//
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   enable                block enable; low in a non-IDLE state aborts to IDLE
//   rx_ant_select         antenna chosen by the receive path (0=ANT1, 1=ANT2)
//   rx_ant_latch          strobe capturing rx_ant_select
//   tx_req                transmit request (honoured in IDLE only)
//   tx_ack                one-cycle pulse: ready for samples
//   data_in               TX IQ sample
//   data_in_strobe        sample valid
//   tx_done               last-sample marker
//   settle_cycles         T/R switch settle time (0 behaves as 1)
//   tail_cycles           PA hold time after the last sample (0 behaves as 1)
//   data_ant1_out/2_out   per-antenna samples, zero on the unselected antenna
//   data_out_strobe       output sample valid
//   tr_switch             1 = TX path
//   pa_en_1, pa_en_2      PA enables (never both high)
//   tx_ant                antenna latched for the current/last burst
//   busy                  high whenever the state is not IDLE
//   force_ant_en/force_ant  (TX_ANT_FORCE_EN only) antenna override
// -----------------------------------------------------------------------------
module tx_ant_switch #(
    parameter int IQ_DATA_WIDTH = 16,
    parameter int CNT_WIDTH     = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       rx_ant_select,
    input  logic                       rx_ant_latch,
    input  logic                       tx_req,
    output logic                       tx_ack,
    input  logic [2*IQ_DATA_WIDTH-1:0] data_in,
    input  logic                       data_in_strobe,
    input  logic                       tx_done,
    input  logic [CNT_WIDTH-1:0]       settle_cycles,
    input  logic [CNT_WIDTH-1:0]       tail_cycles,
    output logic [2*IQ_DATA_WIDTH-1:0] data_ant1_out,
    output logic [2*IQ_DATA_WIDTH-1:0] data_ant2_out,
    output logic                       data_out_strobe,
    output logic                       tr_switch,
    output logic                       pa_en_1,
    output logic                       pa_en_2,
    output logic                       tx_ant,
`ifdef TX_ANT_FORCE_EN
    input  logic                       force_ant_en,
    input  logic                       force_ant,
`endif
    output logic                       busy
);

    localparam int DW = 2 * IQ_DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        ACTIVE = 2'd2,
        TAIL   = 2'd3
    } state_t;

    state_t               state, state_n;
    logic                 last_ant, last_ant_n;
    logic                 tx_ant_n;
    logic                 tr_switch_n;
    logic                 pa_en_1_n, pa_en_2_n;
    logic                 tx_ack_n;
    logic                 data_out_strobe_n;
    logic [DW-1:0]        data_ant1_n, data_ant2_n;
    logic [CNT_WIDTH-1:0] cnt, cnt_n;

    logic [CNT_WIDTH-1:0] settle_last;
    logic [CNT_WIDTH-1:0] tail_last;
    logic                 sel_ant;

    // Terminal counts: a phase of N cycles ends when the counter reaches N-1.
    // Zero is treated as one cycle, so the counter never has to wrap.
    always_comb begin
        settle_last = (settle_cycles == '0) ? '0 : settle_cycles - CNT_WIDTH'(1);
        tail_last   = (tail_cycles   == '0) ? '0 : tail_cycles   - CNT_WIDTH'(1);
    end

    // Antenna used when a request is accepted: a same-cycle latch strobe wins
    // over the stored choice, and the force override wins over both.
    always_comb begin
        sel_ant = rx_ant_latch ? rx_ant_select : last_ant;
`ifdef TX_ANT_FORCE_EN
        if (force_ant_en) begin
            sel_ant = force_ant;
        end
`endif
    end

    always_comb begin
        state_n           = state;
        last_ant_n        = rx_ant_latch ? rx_ant_select : last_ant;
        tx_ant_n          = tx_ant;
        tr_switch_n       = tr_switch;
        pa_en_1_n         = pa_en_1;
        pa_en_2_n         = pa_en_2;
        tx_ack_n          = 1'b0;
        data_out_strobe_n = 1'b0;
        data_ant1_n       = '0;
        data_ant2_n       = '0;
        cnt_n             = cnt;

        case (state)
            IDLE: begin
                if (tx_req && enable) begin
                    tx_ant_n    = sel_ant;
                    tr_switch_n = 1'b1;
                    cnt_n       = '0;
                    state_n     = SETTLE;
                end
            end

            SETTLE: begin
                if (cnt == settle_last) begin
                    state_n   = ACTIVE;
                    tx_ack_n  = 1'b1;
                    pa_en_1_n = ~tx_ant;
                    pa_en_2_n = tx_ant;
                    cnt_n     = '0;
                end else begin
                    cnt_n = cnt + CNT_WIDTH'(1);
                end
            end

            ACTIVE: begin
                if (data_in_strobe) begin
                    data_out_strobe_n = 1'b1;
                    if (tx_ant) begin
                        data_ant2_n = data_in;
                    end else begin
                        data_ant1_n = data_in;
                    end
                end
                if (tx_done) begin
                    state_n = TAIL;
                    cnt_n   = '0;
                end
            end

            TAIL: begin
                if (cnt == tail_last) begin
                    state_n     = IDLE;
                    tr_switch_n = 1'b0;
                    pa_en_1_n   = 1'b0;
                    pa_en_2_n   = 1'b0;
                    cnt_n       = '0;
                end else begin
                    cnt_n = cnt + CNT_WIDTH'(1);
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase

        // Abort: everything returns to its reset value except the stored
        // receive-side antenna choice.
        if ((state != IDLE) && !enable) begin
            state_n           = IDLE;
            tx_ant_n          = 1'b0;
            tr_switch_n       = 1'b0;
            pa_en_1_n         = 1'b0;
            pa_en_2_n         = 1'b0;
            tx_ack_n          = 1'b0;
            data_out_strobe_n = 1'b0;
            data_ant1_n       = '0;
            data_ant2_n       = '0;
            cnt_n             = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= IDLE;
            last_ant        <= 1'b0;
            tx_ant          <= 1'b0;
            tr_switch       <= 1'b0;
            pa_en_1         <= 1'b0;
            pa_en_2         <= 1'b0;
            tx_ack          <= 1'b0;
            data_out_strobe <= 1'b0;
            data_ant1_out   <= '0;
            data_ant2_out   <= '0;
            cnt             <= '0;
        end else begin
            state           <= state_n;
            last_ant        <= last_ant_n;
            tx_ant          <= tx_ant_n;
            tr_switch       <= tr_switch_n;
            pa_en_1         <= pa_en_1_n;
            pa_en_2         <= pa_en_2_n;
            tx_ack          <= tx_ack_n;
            data_out_strobe <= data_out_strobe_n;
            data_ant1_out   <= data_ant1_n;
            data_ant2_out   <= data_ant2_n;
            cnt             <= cnt_n;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_tx_ant_switch.sv
module tb_tx_ant_switch;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        rx_ant_select;
    logic        rx_ant_latch;
    logic        tx_req;
    logic        tx_ack;
    logic [31:0] data_in;
    logic        data_in_strobe;
    logic        tx_done;
    logic [7:0]  settle_cycles;
    logic [7:0]  tail_cycles;
    logic [31:0] data_ant1_out;
    logic [31:0] data_ant2_out;
    logic        data_out_strobe;
    logic        tr_switch;
    logic        pa_en_1;
    logic        pa_en_2;
    logic        tx_ant;
    logic        busy;
`ifdef TX_ANT_FORCE_EN
    logic        force_ant_en;
    logic        force_ant;
`endif

    int checks   = 0;
    int failures = 0;

    // expected {data_ant1_out, data_ant2_out} for each output strobe
    logic [63:0] exp_q[$];

    tx_ant_switch #(
        .IQ_DATA_WIDTH(16),
        .CNT_WIDTH(8)
    ) dut (
        .clock(clock),
        .reset(reset),
        .enable(enable),
        .rx_ant_select(rx_ant_select),
        .rx_ant_latch(rx_ant_latch),
        .tx_req(tx_req),
        .tx_ack(tx_ack),
        .data_in(data_in),
        .data_in_strobe(data_in_strobe),
        .tx_done(tx_done),
        .settle_cycles(settle_cycles),
        .tail_cycles(tail_cycles),
        .data_ant1_out(data_ant1_out),
        .data_ant2_out(data_ant2_out),
        .data_out_strobe(data_out_strobe),
        .tr_switch(tr_switch),
        .pa_en_1(pa_en_1),
        .pa_en_2(pa_en_2),
        .tx_ant(tx_ant),
`ifdef TX_ANT_FORCE_EN
        .force_ant_en(force_ant_en),
        .force_ant(force_ant),
`endif
        .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // {tr_switch, pa_en_1, pa_en_2, tx_ack, busy, tx_ant, data_out_strobe}
    function automatic logic [6:0] ctl();
        return {tr_switch, pa_en_1, pa_en_2, tx_ack, busy, tx_ant, data_out_strobe};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic done, input logic ant);
        data_in        = d;
        data_in_strobe = 1'b1;
        tx_done        = done;
        exp_q.push_back(ant ? {32'h0, d} : {d, 32'h0});
        tick();
        data_in_strobe = 1'b0;
        tx_done        = 1'b0;
        data_in        = '0;
    endtask

    // Monitor: every output strobe must match the next queued expectation;
    // without a strobe both antenna outputs must be zero.
    always @(negedge clock) begin
        if (reset === 1'b0) begin
            if (data_out_strobe) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", {data_ant1_out, data_ant2_out}, 64'hX);
                end else begin
                    check("sample", {data_ant1_out, data_ant2_out}, exp_q.pop_front());
                end
            end else if ((data_ant1_out | data_ant2_out) != '0) begin
                check("idle_data_zero", {data_ant1_out, data_ant2_out}, 64'h0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset          = 1'b1;
        enable         = 1'b1;
        rx_ant_select  = 1'b0;
        rx_ant_latch   = 1'b0;
        tx_req         = 1'b0;
        data_in        = '0;
        data_in_strobe = 1'b0;
        tx_done        = 1'b0;
        settle_cycles  = 8'd4;
        tail_cycles    = 8'd2;
`ifdef TX_ANT_FORCE_EN
        force_ant_en   = 1'b0;
        force_ant      = 1'b0;
`endif
        tick();
        tick();
        reset = 1'b0;
        check("reset_ctl", 64'(ctl()), 64'h0);

        // Packet A: latch ANT2, then request with settle_cycles=4
        rx_ant_select = 1'b1;
        rx_ant_latch  = 1'b1;
        tick();
        rx_ant_latch  = 1'b0;
        rx_ant_select = 1'b0;
        tx_req        = 1'b1;
        tick();
        tx_req = 1'b0;
        check("a_settle_ctl", 64'(ctl()), 64'b1000110);
        data_in_strobe = 1'b1;            // dropped in SETTLE
        data_in        = 32'hDEADBEEF;
        tick();
        data_in_strobe = 1'b0;
        data_in        = '0;
        tick();
        tick();
        check("a_no_ack_early", 64'(tx_ack), 64'h0);
        tick();
        check("a_ack_ctl", 64'(ctl()), 64'b1011110);
        tick();
        check("a_ack_one_cycle", 64'(ctl()), 64'b1010110);
        send(32'hAABBCCDD, 1'b1, 1'b1);   // tail_cycles=2
        check("a_tail1", 64'(ctl()), 64'b1010111);
        tick();
        check("a_tail2", 64'(ctl()), 64'b1010110);
        tick();
        check("a_idle", 64'({tr_switch, pa_en_1, pa_en_2, busy}), 64'h0);

        // Strobe in IDLE is dropped
        data_in_strobe = 1'b1;
        data_in        = 32'h12345678;
        tick();
        data_in_strobe = 1'b0;
        data_in        = '0;
        check("idle_drop", 64'({data_out_strobe, data_ant1_out, data_ant2_out}), 64'h0);

        // Packet B: same-cycle latch of ANT1, settle_cycles=0 acts as 1
        settle_cycles = 8'd0;
        tail_cycles   = 8'd3;
        rx_ant_select = 1'b0;
        rx_ant_latch  = 1'b1;
        tx_req        = 1'b1;
        tick();
        rx_ant_latch = 1'b0;
        tx_req       = 1'b0;
        check("b_settle_ant", 64'({tr_switch, tx_ant, tx_ack}), 64'b100);
        tick();
        check("b_ack_ctl", 64'(ctl()), 64'b1101100);
        rx_ant_select = 1'b1;             // new choice while ACTIVE
        rx_ant_latch  = 1'b1;
        tx_req        = 1'b1;             // ignored outside IDLE
        send(32'h00010002, 1'b0, 1'b0);
        rx_ant_latch = 1'b0;
        rx_ant_select = 1'b0;
        tx_req = 1'b0;
        send(32'h00030004, 1'b0, 1'b0);
        check("b_ant_kept", 64'({tx_ant, pa_en_1, pa_en_2}), 64'b010);
        send(32'h00050006, 1'b1, 1'b0);
        check("b_tail1", 64'({pa_en_1, tr_switch, busy}), 64'b111);
        tick();
        check("b_tail2", 64'({pa_en_1, tr_switch, busy}), 64'b111);
        tick();
        check("b_tail3", 64'({pa_en_1, tr_switch, busy}), 64'b111);
        tick();
        check("b_idle", 64'({pa_en_1, tr_switch, busy}), 64'b000);

        // Packet C: uses ANT2 latched during packet B, then enable abort
        settle_cycles = 8'd1;
        tx_req        = 1'b1;
        tick();
        tx_req = 1'b0;
        check("c_new_ant", 64'(tx_ant), 64'h1);
        tick();
        check("c_pa2", 64'({pa_en_1, pa_en_2}), 64'b01);
        send(32'h0BADF00D, 1'b0, 1'b1);
        enable = 1'b0;
        tick();
        check("c_abort_ctl", 64'(ctl()), 64'h0);
        enable = 1'b1;
        tx_req = 1'b1;
        tick();
        tx_req = 1'b0;
        check("c_last_ant_kept", 64'(tx_ant), 64'h1);

        // Reset mid-packet clears the stored antenna
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("d_reset_ctl", 64'(ctl()), 64'h0);
        tx_req = 1'b1;
        tick();
        tx_req = 1'b0;
        check("d_last_ant_zero", 64'({tr_switch, tx_ant}), 64'b10);
        enable = 1'b0;
        tick();
        enable = 1'b1;

`ifdef TX_ANT_FORCE_EN
        rx_ant_select = 1'b1;
        rx_ant_latch  = 1'b1;
        tick();
        rx_ant_latch  = 1'b0;
        force_ant_en  = 1'b1;
        force_ant     = 1'b0;
        tx_req        = 1'b1;
        tick();
        tx_req       = 1'b0;
        force_ant_en = 1'b0;
        tick();
        check("e_force_pa", 64'({pa_en_1, pa_en_2, tx_ant}), 64'b100);
        enable = 1'b0;
        tick();
        enable = 1'b1;
`endif

        tick();
        tick();
        check("queue_drained", 64'(exp_q.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
